// File: rtl/holy_irq_arbiter.sv
// rtl/holy_irq_arbiter.sv - interrupt gateways, priority arbiter and claim/complete sequencer; edge trigger option HOLY_IRQ_EDGE_EN
module holy_irq_arbiter #(
    parameter int NUM_IRQS = 5,
    parameter int PRIO_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic                cfg_we,
    input  logic                cfg_re,
    input  logic [7:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    input  logic                claim_req,
    output logic                claim_valid,
    output logic [4:0]          claim_id,
    input  logic                complete_valid,
    input  logic [4:0]          complete_id,
    output logic                irq_o
);

    localparam int IDW = 5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PENDING  = 2'd1;
    localparam logic [1:0] ST_INFLIGHT = 2'd2;

    localparam logic [7:0] ADDR_ENABLE = 8'h00;
    localparam logic [7:0] ADDR_THRESH = 8'h04;
    localparam logic [7:0] ADDR_EDGE   = 8'h08;
    localparam logic [7:0] ADDR_PRIO   = 8'h10;

    logic [NUM_IRQS-1:0] enable_q, enable_d;
    logic [PRIO_W-1:0]   threshold_q, threshold_d;
    logic [PRIO_W-1:0]   prio_q [NUM_IRQS];
    logic [PRIO_W-1:0]   prio_d [NUM_IRQS];
    logic [31:0]         cfg_rdata_q, cfg_rdata_d;
    logic [1:0]          state_q [NUM_IRQS];
    logic [1:0]          state_d [NUM_IRQS];
    logic [IDW-1:0]      best_id_q, best_id_d;
    logic [PRIO_W-1:0]   best_prio_q, best_prio_d;
    logic                claim_valid_q, claim_valid_d;
    logic [IDW-1:0]      claim_id_q, claim_id_d;

    logic [NUM_IRQS-1:0] trigger;
    logic [NUM_IRQS-1:0] edge_hit;
    logic [NUM_IRQS-1:0] missed_now;
    logic [NUM_IRQS-1:0] complete_hit;
    logic [NUM_IRQS-1:0] claim_hit;
    logic [NUM_IRQS-1:0] pending;
    logic [NUM_IRQS-1:0] eligible;
    logic [IDW-1:0]      arb_id;
    logic [PRIO_W-1:0]   arb_prio;
    logic [31:0]         rd_value;

`ifdef HOLY_IRQ_EDGE_EN
    logic [NUM_IRQS-1:0] edge_q, edge_d;
    logic [NUM_IRQS-1:0] irq_prev_q;
    logic [NUM_IRQS-1:0] missed_q, missed_d;
    logic [NUM_IRQS-1:0] rise;

    // Edge sources fire on a 0->1 step of irq_in; level sources fire while high
    always_comb begin
        rise       = irq_in & ~irq_prev_q;
        edge_hit   = edge_q & rise;
        trigger    = edge_hit | (~edge_q & irq_in);
        missed_now = missed_q;
    end

    // Remember (merged) edges seen while in service; cleared when service ends
    always_comb begin
        missed_d = missed_q;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (state_q[i] == ST_INFLIGHT) begin
                if (complete_hit[i]) begin
                    missed_d[i] = 1'b0;
                end else if (edge_hit[i]) begin
                    missed_d[i] = 1'b1;
                end
            end
        end
    end

    // EDGE register write decode
    always_comb begin
        edge_d = edge_q;
        if (cfg_we && cfg_addr == ADDR_EDGE) begin
            edge_d = cfg_wdata[NUM_IRQS-1:0];
        end
    end

    // Edge-mode state: trigger type, previous input sample, missed flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q     <= '0;
            irq_prev_q <= '0;
            missed_q   <= '0;
        end else begin
            edge_q     <= edge_d;
            irq_prev_q <= irq_in;
            missed_q   <= missed_d;
        end
    end
`else
    // Level trigger only
    always_comb begin
        trigger    = irq_in;
        edge_hit   = '0;
        missed_now = '0;
    end
`endif

    // Configuration register write decode
    always_comb begin
        enable_d    = enable_q;
        threshold_d = threshold_q;
        prio_d      = prio_q;
        if (cfg_we) begin
            if (cfg_addr == ADDR_ENABLE) begin
                enable_d = cfg_wdata[NUM_IRQS-1:0];
            end
            if (cfg_addr == ADDR_THRESH) begin
                threshold_d = cfg_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (cfg_addr == 8'(ADDR_PRIO + 8'(4 * i))) begin
                    prio_d[i] = cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Read mux; the returned word is held until the next read strobe
    always_comb begin
        rd_value = '0;
        if (cfg_addr == ADDR_ENABLE) begin
            rd_value[NUM_IRQS-1:0] = enable_q;
        end
        if (cfg_addr == ADDR_THRESH) begin
            rd_value[PRIO_W-1:0] = threshold_q;
        end
`ifdef HOLY_IRQ_EDGE_EN
        if (cfg_addr == ADDR_EDGE) begin
            rd_value[NUM_IRQS-1:0] = edge_q;
        end
`endif
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (cfg_addr == 8'(ADDR_PRIO + 8'(4 * i))) begin
                rd_value[PRIO_W-1:0] = prio_q[i];
            end
        end
        cfg_rdata_d = cfg_re ? rd_value : cfg_rdata_q;
    end

    // Per-source claim/complete decode; out-of-range and zero IDs match nothing
    always_comb begin
        for (int i = 0; i < NUM_IRQS; i++) begin
            complete_hit[i] = complete_valid && (complete_id == IDW'(i + 1));
            claim_hit[i]    = claim_req && (best_id_q == IDW'(i + 1));
        end
    end

    // Gateway next-state logic
    always_comb begin
        for (int i = 0; i < NUM_IRQS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (trigger[i]) state_d[i] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (claim_hit[i]) state_d[i] = ST_INFLIGHT;
                end
                ST_INFLIGHT: begin
                    if (complete_hit[i]) begin
                        state_d[i] = (missed_now[i] || edge_hit[i]) ? ST_PENDING : ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Gateway outputs: eligibility for arbitration
    always_comb begin
        for (int i = 0; i < NUM_IRQS; i++) begin
            pending[i]  = (state_q[i] == ST_PENDING);
            eligible[i] = pending[i] && enable_q[i] && (prio_q[i] > threshold_q);
        end
    end

    // Arbitration: strictly-greater compare in ascending ID order keeps the lowest ID on ties;
    // a successful claim blanks the result for one cycle so the claimed source cannot be re-issued
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (eligible[i] && prio_q[i] > arb_prio) begin
                arb_id   = IDW'(i + 1);
                arb_prio = prio_q[i];
            end
        end
        if (claim_req && best_id_q != '0) begin
            best_id_d   = '0;
            best_prio_d = '0;
        end else begin
            best_id_d   = arb_id;
            best_prio_d = arb_prio;
        end
    end

    // Claim response is a single-cycle pulse carrying the sampled winner
    always_comb begin
        claim_valid_d = claim_req;
        claim_id_d    = claim_req ? best_id_q : '0;
    end

    // All state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q      <= '0;
            threshold_q   <= '0;
            cfg_rdata_q   <= '0;
            best_id_q     <= '0;
            best_prio_q   <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            for (int i = 0; i < NUM_IRQS; i++) begin
                prio_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            enable_q      <= enable_d;
            threshold_q   <= threshold_d;
            cfg_rdata_q   <= cfg_rdata_d;
            best_id_q     <= best_id_d;
            best_prio_q   <= best_prio_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            for (int i = 0; i < NUM_IRQS; i++) begin
                prio_q[i]  <= prio_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign cfg_rdata   = cfg_rdata_q;
    assign claim_valid = claim_valid_q;
    assign claim_id    = claim_id_q;
    assign irq_o       = (best_id_q != '0);

    // Bits of the buses that the register map never consumes
    logic unused_sink;
    assign unused_sink = ^{cfg_addr[1:0], cfg_wdata, best_prio_q};

endmodule

// File: tb/tb_holy_irq_arbiter.sv
// tb/tb_holy_irq_arbiter.sv - directed self-checking bench for holy_irq_arbiter
module tb_holy_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  irq_in = '0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        claim_req = 1'b0;
    logic        claim_valid;
    logic [4:0]  claim_id;
    logic        complete_valid = 1'b0;
    logic [4:0]  complete_id = '0;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    holy_irq_arbiter #(.NUM_IRQS(5), .PRIO_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .cfg_we         (cfg_we),
        .cfg_re         (cfg_re),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .claim_req      (claim_req),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cfg_addr = a;
        cfg_re   = 1'b1;
        tick();
        cfg_re   = 1'b0;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic claim(input string tag, input logic [4:0] exp);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        chk({tag, "_valid"}, {31'd0, claim_valid}, 32'd1);
        chk({tag, "_id"}, {27'd0, claim_id}, {27'd0, exp});
    endtask

    task automatic complete(input logic [4:0] id);
        complete_id    = id;
        complete_valid = 1'b1;
        tick();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_irq_o", {31'd0, irq_o}, 32'd0);
        chk("rst_claim_valid", {31'd0, claim_valid}, 32'd0);
        chk("rst_claim_id", {27'd0, claim_id}, 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        rst = 1'b0;
        tick();
        rd("rst_enable", 8'h00, 32'd0);
        rd("rst_prio1", 8'h10, 32'd0);

        // Basic service of ID3
        wr(8'h00, 32'h1F);
        wr(8'h18, 32'd2);
        wr(8'h04, 32'd0);
        rd("rd_prio3", 8'h18, 32'd2);
        rd("rd_unmapped", 8'h0C, 32'd0);
        rd("rd_enable", 8'h00, 32'h1F);
        tick();
        tick();
        chk("rd_hold", cfg_rdata, 32'h1F);
        irq_in = 5'b00100;
        tick();
        chk("t1_lat1", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t1_lat2", {31'd0, irq_o}, 32'd1);
        claim("t1_claim", 5'd3);
        chk("t1_blank", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t1_pulse_end", {31'd0, claim_valid}, 32'd0);
        chk("t1_inflight_a", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t1_inflight_b", {31'd0, irq_o}, 32'd0);
        complete(5'd3);
        chk("t1_cmp0", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t1_cmp1", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t1_repend", {31'd0, irq_o}, 32'd1);
        irq_in = 5'b00000;
        claim("t1_claim2", 5'd3);
        complete(5'd3);
        tick();
        tick();
        chk("t1_idle", {31'd0, irq_o}, 32'd0);

        // Priority and tie-break
        wr(8'h14, 32'd5);
        wr(8'h1C, 32'd5);
        wr(8'h20, 32'd7);
        irq_in = 5'b11010;
        tick();
        tick();
        chk("t2_irq", {31'd0, irq_o}, 32'd1);
        claim("t2_first", 5'd5);
        irq_in = 5'b01010;
        complete(5'd5);
        claim("t2_second", 5'd2);
        irq_in = 5'b01000;
        complete(5'd2);
        claim("t2_third", 5'd4);
        irq_in = 5'b00000;
        complete(5'd4);
        tick();
        tick();
        chk("t2_drained", {31'd0, irq_o}, 32'd0);

        // Threshold is strictly-greater
        wr(8'h10, 32'd3);
        wr(8'h04, 32'd3);
        irq_in = 5'b00001;
        tick();
        tick();
        tick();
        chk("t3_equal", {31'd0, irq_o}, 32'd0);
        wr(8'h04, 32'd2);
        chk("t3_w1", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t3_w2", {31'd0, irq_o}, 32'd1);

        // Back-to-back claims and bogus completes
        wr(8'h14, 32'd3);
        irq_in = 5'b00011;
        tick();
        tick();
        chk("t4_irq", {31'd0, irq_o}, 32'd1);
        claim_req = 1'b1;
        tick();
        chk("t4_c0_valid", {31'd0, claim_valid}, 32'd1);
        chk("t4_c0_id", {27'd0, claim_id}, 32'd1);
        tick();
        chk("t4_c1_valid", {31'd0, claim_valid}, 32'd1);
        chk("t4_c1_id", {27'd0, claim_id}, 32'd0);
        tick();
        chk("t4_c2_id", {27'd0, claim_id}, 32'd2);
        claim_req = 1'b0;
        complete(5'd7);
        complete(5'd0);
        tick();
        chk("t4_bogus_a", {31'd0, irq_o}, 32'd0);
        tick();
        chk("t4_bogus_b", {31'd0, irq_o}, 32'd0);
        complete(5'd1);
        tick();
        tick();
        chk("t4_repend", {31'd0, irq_o}, 32'd1);
        claim("t4_c3", 5'd1);
        tick();
        chk("t4_id2_held", {31'd0, irq_o}, 32'd0);

        // ENABLE clear keeps PENDING
        complete(5'd1);
        tick();
        tick();
        chk("t5_pend", {31'd0, irq_o}, 32'd1);
        wr(8'h00, 32'h1E);
        tick();
        chk("t5_disabled", {31'd0, irq_o}, 32'd0);
        wr(8'h00, 32'h1F);
        tick();
        chk("t5_reenabled", {31'd0, irq_o}, 32'd1);

        // Asynchronous reset mid-service (ID2 in flight, ID1 pending)
        rd("t6_rd", 8'h00, 32'h1F);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_irq", {31'd0, irq_o}, 32'd0);
        chk("t6_async_rdata", cfg_rdata, 32'd0);
        chk("t6_async_cv", {31'd0, claim_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_after", {31'd0, irq_o}, 32'd0);
        rd("t6_enable", 8'h00, 32'd0);
        rd("t6_prio2", 8'h14, 32'd0);
        wr(8'h00, 32'h03);
        wr(8'h14, 32'd4);
        tick();
        chk("t6_fresh_irq", {31'd0, irq_o}, 32'd1);
        claim("t6_claim2", 5'd2);

        irq_in = 5'b00000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

`ifdef HOLY_IRQ_EDGE_EN
        // Edge mode with merged missed edges
        wr(8'h08, 32'h01);
        wr(8'h00, 32'h01);
        wr(8'h10, 32'd1);
        rd("e_edge_rd", 8'h08, 32'h01);
        irq_in = 5'b00001;
        tick();
        irq_in = 5'b00000;
        tick();
        chk("e_pend", {31'd0, irq_o}, 32'd1);
        claim("e_claim1", 5'd1);
        irq_in = 5'b00001;
        tick();
        irq_in = 5'b00000;
        tick();
        irq_in = 5'b00001;
        tick();
        irq_in = 5'b00000;
        tick();
        chk("e_inflight", {31'd0, irq_o}, 32'd0);
        complete(5'd1);
        tick();
        chk("e_missed", {31'd0, irq_o}, 32'd1);
        claim("e_claim2", 5'd1);
        complete(5'd1);
        tick();
        tick();
        chk("e_idle", {31'd0, irq_o}, 32'd0);
        claim("e_claim_none", 5'd0);
`else
        // EDGE register absent
        wr(8'h08, 32'h01);
        rd("noedge_rd", 8'h08, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
